// File: rtl/spi_flash_responder.sv
// Answers SPI READ/FAST_READ from the SDRAM flash image. Data is ready busy-wait + SDRAM latency + 1 cycle after ISSUE entry.
// Stalls on sd_busy or a still-outstanding read; host strobes that arrive during WAIT are counted as misses.
module spi_flash_responder #(
    parameter int          ADDR_BITS = 25,
    parameter logic [7:0]  READ_CMD  = 8'h03,
    parameter logic [7:0]  FAST_CMD  = 8'h0B
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_rx_strobe,
    input  logic                 spi_rx_cmd,
    input  logic [7:0]           spi_rx_data,
    output logic [7:0]           spi_tx_data,
    output logic [ADDR_BITS-1:0] sd_addr,
    output logic                 sd_enable,
    output logic                 sd_we,
    input  logic [7:0]           sd_rd_data,
    input  logic                 sd_rd_ready,
    input  logic                 sd_busy,
    output logic                 sd_refresh_inhibit,
    output logic [15:0]          miss_count
);

    typedef enum logic [2:0] {IDLE, ADDR, DUMMY, ISSUE, WAIT, DATA} state_t;

    state_t      state;
    logic [23:0] addr;
    logic [1:0]  byte_cnt;
    logic        fast;
    logic        rd_outstanding;

    logic rx_cmd;
    logic rx_byte;

    assign rx_cmd             = spi_rx_strobe & spi_rx_cmd;
    assign rx_byte            = spi_rx_strobe & ~spi_rx_cmd;
    assign sd_we              = 1'b0;
    assign sd_refresh_inhibit = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            spi_tx_data    <= 8'hFF;
            sd_enable      <= 1'b0;
            sd_addr        <= '0;
            miss_count     <= 16'd0;
            rd_outstanding <= 1'b0;
            addr           <= 24'd0;
            byte_cnt       <= 2'd0;
            fast           <= 1'b0;
        end else begin
            sd_enable <= 1'b0;
            // Any returning read retires the outstanding one, even if it is discarded.
            if (sd_rd_ready) begin
                rd_outstanding <= 1'b0;
            end

            if (rx_cmd) begin
                spi_tx_data <= 8'hFF;
                byte_cnt    <= 2'd0;
                if (spi_rx_data == READ_CMD) begin
                    state <= ADDR;
                    fast  <= 1'b0;
                end else if (spi_rx_data == FAST_CMD) begin
                    state <= ADDR;
                    fast  <= 1'b1;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                    end
                    ADDR: begin
                        if (rx_byte) begin
                            case (byte_cnt)
                                2'd0:    addr[23:16] <= spi_rx_data;
                                2'd1:    addr[15:8]  <= spi_rx_data;
                                default: addr[7:0]   <= spi_rx_data;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd2) begin
                                state <= fast ? DUMMY : ISSUE;
                            end
                        end
                    end
                    DUMMY: begin
                        if (rx_byte) begin
                            state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (!sd_busy && !rd_outstanding) begin
                            sd_enable      <= 1'b1;
                            sd_addr        <= {{(ADDR_BITS-24){1'b0}}, addr};
                            rd_outstanding <= 1'b1;
                            state          <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (sd_rd_ready) begin
                            spi_tx_data <= sd_rd_data;
                            addr        <= addr + 24'd1;
                            state       <= DATA;
                        end
                        // The host clocked out a byte we had not fetched yet.
                        if (rx_byte && miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                    end
                    DATA: begin
                        if (rx_byte) begin
                            state <= ISSUE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SDRAM model plus read-address and tx-data scoreboards.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_rx_strobe, spi_rx_cmd;
    logic [7:0]  spi_rx_data, spi_tx_data, sd_rd_data;
    logic [24:0] sd_addr;
    logic        sd_enable, sd_we, sd_rd_ready, sd_busy, sd_refresh_inhibit;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .clk(clk), .reset(reset),
        .spi_rx_strobe(spi_rx_strobe), .spi_rx_cmd(spi_rx_cmd), .spi_rx_data(spi_rx_data),
        .spi_tx_data(spi_tx_data), .sd_addr(sd_addr), .sd_enable(sd_enable), .sd_we(sd_we),
        .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy),
        .sd_refresh_inhibit(sd_refresh_inhibit), .miss_count(miss_count)
    );

    logic [7:0]  image [int];
    logic [23:0] exp_addr_q [$];
    logic [7:0]  exp_tx_q [$];
    int compared = 0, mismatched = 0;
    int enable_count = 0, ready_count = 0, latency = 3;
    bit model_busy = 1'b0;

    // SDRAM model: one read at a time, data returned `latency` cycles after the request.
    task automatic serve(input logic [24:0] a);
        logic [7:0] d;
        logic [7:0] e;
        d = image.exists(int'(a)) ? image[int'(a)] : 8'h00;
        repeat (latency) @(posedge clk);
        #1 sd_rd_data = d; sd_rd_ready = 1'b1;
        @(posedge clk);
        #1 sd_rd_ready = 1'b0; sd_rd_data = 8'h00; model_busy = 1'b0;
        @(negedge clk);
        compared++;
        if (exp_tx_q.size() == 0) begin
            mismatched++; $display("FAIL tx_after_ready: spi_tx_data=%h but no expectation queued", spi_tx_data);
        end else begin
            e = exp_tx_q.pop_front();
            if (spi_tx_data !== e) begin
                mismatched++; $display("FAIL tx_after_ready: spi_tx_data=%h expected %h", spi_tx_data, e);
            end
        end
        ready_count++;
    endtask

    always @(negedge clk) begin : req_monitor
        logic [24:0] e_addr;
        if (sd_enable) begin
            enable_count++;
            compared++;
            if (model_busy) begin
                mismatched++; $display("FAIL issue_while_outstanding: sd_addr=%h issued before previous read returned", sd_addr);
            end
            compared++;
            if (exp_addr_q.size() == 0) begin
                mismatched++; $display("FAIL unexpected_read: sd_addr=%h with no read expected", sd_addr);
            end else begin
                e_addr = {1'b0, exp_addr_q.pop_front()};
                if (sd_addr !== e_addr) begin
                    mismatched++; $display("FAIL read_addr: sd_addr=%h expected %h", sd_addr, e_addr);
                end
            end
            model_busy = 1'b1;
            fork
                serve(sd_addr);
            join_none
        end
    end

    task automatic send(input logic is_cmd, input logic [7:0] d);
        @(posedge clk);
        #1 spi_rx_strobe = 1'b1; spi_rx_cmd = is_cmd; spi_rx_data = d;
        @(posedge clk);
        #1 spi_rx_strobe = 1'b0; spi_rx_cmd = 1'b0; spi_rx_data = 8'h00;
    endtask

    task automatic send_read(input logic [7:0] op, input logic [23:0] a);
        send(1'b1, op);
        send(1'b0, a[23:16]);
        send(1'b0, a[15:8]);
        send(1'b0, a[7:0]);
    endtask

    task automatic wait_reads(input int target, input int budget);
        int n = 0;
        while (ready_count < target && n < budget) begin
            @(posedge clk); n++;
        end
        compared++;
        if (ready_count < target) begin
            mismatched++; $display("FAIL read_timeout: %0d reads completed, required %0d", ready_count, target);
        end
    endtask

    task automatic wait_enable(input int target, input int budget);
        int n = 0;
        while (enable_count < target && n < budget) begin
            @(posedge clk); n++;
        end
        compared++;
        if (enable_count < target) begin
            mismatched++; $display("FAIL enable_timeout: %0d requests seen, required %0d", enable_count, target);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (spi_tx_data !== 8'hFF) begin mismatched++; $display("FAIL reset_tx: got %h expected ff", spi_tx_data); end
        compared++; if (sd_enable !== 1'b0) begin mismatched++; $display("FAIL reset_enable: got %b expected 0", sd_enable); end
        compared++; if (sd_addr !== 25'd0) begin mismatched++; $display("FAIL reset_addr: got %h expected 0", sd_addr); end
        compared++; if (miss_count !== 16'd0) begin mismatched++; $display("FAIL reset_miss: got %0d expected 0", miss_count); end
        compared++; if (sd_refresh_inhibit !== 1'b0) begin mismatched++; $display("FAIL reset_inhibit: got %b expected 0", sd_refresh_inhibit); end
        compared++; if (sd_we !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %b expected 0", sd_we); end
        reset = 1'b0;
    endtask

    task automatic test_plain_read;
        logic [7:0] vals [4];
        int base;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) image[32'h100 + i] = vals[i];
        base = ready_count;
        exp_addr_q.push_back(24'h000100); exp_tx_q.push_back(vals[0]);
        send_read(8'h03, 24'h000100);
        compared++; if (sd_refresh_inhibit !== 1'b1) begin mismatched++; $display("FAIL plain_inhibit: got %b expected 1", sd_refresh_inhibit); end
        wait_reads(base + 1, 50);
        for (int i = 1; i < 4; i++) begin
            exp_addr_q.push_back(24'h000100 + 24'(i)); exp_tx_q.push_back(vals[i]);
            send(1'b0, 8'h00);
            wait_reads(base + 1 + i, 50);
        end
        compared++; if (miss_count !== 16'd0) begin mismatched++; $display("FAIL plain_miss: got %0d expected 0", miss_count); end
    endtask

    task automatic test_fast_read;
        int e0, base;
        image[32'h10] = 8'hA5;
        base = ready_count;
        send_read(8'h0B, 24'h000010);
        e0 = enable_count;
        repeat (5) @(posedge clk);
        #1;
        compared++; if (enable_count !== e0) begin mismatched++; $display("FAIL fast_no_early_read: %0d requests before dummy, expected 0", enable_count - e0); end
        exp_addr_q.push_back(24'h000010); exp_tx_q.push_back(8'hA5);
        send(1'b0, 8'h00);
        wait_reads(base + 1, 50);
    endtask

    task automatic test_wrap_busy;
        int e0, base;
        image[32'hFFFFFF] = 8'hC3;
        image[32'h0]      = 8'h3C;
        base = ready_count;
        sd_busy = 1'b1;
        exp_addr_q.push_back(24'hFFFFFF); exp_tx_q.push_back(8'hC3);
        send_read(8'h03, 24'hFFFFFF);
        e0 = enable_count;
        repeat (20) @(posedge clk);
        #1;
        compared++; if (enable_count !== e0) begin mismatched++; $display("FAIL busy_hold: %0d requests while busy, expected 0", enable_count - e0); end
        sd_busy = 1'b0;
        wait_reads(base + 1, 50);
        exp_addr_q.push_back(24'h000000); exp_tx_q.push_back(8'h3C);
        send(1'b0, 8'h00);
        wait_reads(base + 2, 50);
    endtask

    task automatic test_miss;
        int base;
        image[32'h200] = 8'h77;
        base = ready_count;
        latency = 50;
        exp_addr_q.push_back(24'h000200); exp_tx_q.push_back(8'h77);
        send_read(8'h03, 24'h000200);
        wait_enable(enable_count + 1, 20);
        repeat (5) @(posedge clk);
        send(1'b0, 8'h00);
        compared++; if (miss_count !== 16'd1) begin mismatched++; $display("FAIL miss_count: got %0d expected 1", miss_count); end
        compared++; if (spi_tx_data !== 8'hFF) begin mismatched++; $display("FAIL miss_tx_hold: got %h expected ff", spi_tx_data); end
        wait_reads(base + 1, 100);
        latency = 3;
        compared++; if (miss_count !== 16'd1) begin mismatched++; $display("FAIL miss_after_data: got %0d expected 1", miss_count); end
    endtask

    task automatic test_abort;
        int e1, base;
        image[32'h300] = 8'h5A;
        image[32'h301] = 8'hA1;
        base = ready_count;
        latency = 30;
        exp_addr_q.push_back(24'h000300); exp_tx_q.push_back(8'hFF);
        send_read(8'h03, 24'h000300);
        wait_enable(enable_count + 1, 20);
        repeat (3) @(posedge clk);
        send(1'b1, 8'h9F);
        compared++; if (spi_tx_data !== 8'hFF) begin mismatched++; $display("FAIL abort_tx: got %h expected ff", spi_tx_data); end
        compared++; if (sd_refresh_inhibit !== 1'b0) begin mismatched++; $display("FAIL abort_idle: inhibit %b expected 0", sd_refresh_inhibit); end
        latency = 3;
        e1 = enable_count;
        exp_addr_q.push_back(24'h000301); exp_tx_q.push_back(8'hA1);
        send_read(8'h03, 24'h000301);
        repeat (2) @(posedge clk);
        #1;
        compared++; if (enable_count !== e1) begin mismatched++; $display("FAIL abort_stall: %0d requests before late data, expected 0", enable_count - e1); end
        compared++; if (sd_refresh_inhibit !== 1'b1) begin mismatched++; $display("FAIL abort_reissue_inhibit: got %b expected 1", sd_refresh_inhibit); end
        wait_reads(base + 2, 100);
    endtask

    task automatic test_reset_in_wait;
        int e0, base;
        image[32'h400] = 8'h99;
        base = ready_count;
        latency = 20;
        exp_addr_q.push_back(24'h000400); exp_tx_q.push_back(8'hFF);
        send_read(8'h03, 24'h000400);
        wait_enable(enable_count + 1, 20);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        compared++; if (spi_tx_data !== 8'hFF) begin mismatched++; $display("FAIL rst_wait_tx: got %h expected ff", spi_tx_data); end
        compared++; if (sd_addr !== 25'd0) begin mismatched++; $display("FAIL rst_wait_addr: got %h expected 0", sd_addr); end
        compared++; if (miss_count !== 16'd0) begin mismatched++; $display("FAIL rst_wait_miss: got %0d expected 0", miss_count); end
        compared++; if (sd_refresh_inhibit !== 1'b0) begin mismatched++; $display("FAIL rst_wait_inhibit: got %b expected 0", sd_refresh_inhibit); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        e0 = enable_count;
        wait_reads(base + 1, 60);
        latency = 3;
        repeat (5) @(posedge clk);
        #1;
        compared++; if (enable_count !== e0) begin mismatched++; $display("FAIL rst_no_request: %0d requests after reset, expected 0", enable_count - e0); end
    endtask

    initial begin
        spi_rx_strobe = 1'b0; spi_rx_cmd = 1'b0; spi_rx_data = 8'h00;
        sd_rd_data = 8'h00; sd_rd_ready = 1'b0; sd_busy = 1'b0;
        test_reset;
        test_plain_read;
        test_fast_read;
        test_wrap_busy;
        test_miss;
        test_abort;
        test_reset_in_wait;
        repeat (5) @(posedge clk);
        compared++;
        if (exp_addr_q.size() != 0 || exp_tx_q.size() != 0) begin
            mismatched++; $display("FAIL leftover: %0d reads and %0d tx values still expected, required 0", exp_addr_q.size(), exp_tx_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
